// File: rtl/maxpool_sched_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool scheduler: FSM state
// enumeration, pooling geometry and address-width helpers.
package maxpool_sched_pkg;

  localparam int unsigned POOL   = 2;
  localparam int unsigned STRIDE = 2;
  localparam int unsigned TAPS   = POOL * POOL;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DRAIN,
    WR,
    FIN
  } state_t;

  // ceil(log2(n)), never below 1 so degenerate sizes still give a legal vector
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned in_aw(input int unsigned ch,
                                        input int unsigned w,
                                        input int unsigned h);
    return clog2_min1(ch * w * h);
  endfunction

  function automatic int unsigned out_aw(input int unsigned ch,
                                         input int unsigned w,
                                         input int unsigned h);
    return clog2_min1(ch * (w / STRIDE) * (h / STRIDE));
  endfunction

endpackage

// File: rtl/maxpool_cmp.sv
// Running-maximum register for one pooling window.
//   clk/rst : clock, synchronous active-low reset (clears the maximum)
//   load    : take din unconditionally (first tap of a window)
//   en      : take din only when it is strictly greater (signed)
//   din     : signed sample
//   max     : current window maximum
module maxpool_cmp
  import maxpool_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] max
);

  logic signed [DATA_W-1:0] r_max;

  // first tap seeds the register, so no sentinel value is ever compared
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_max <= '0;
    end else if (load) begin
      r_max <= din;
    end else if (en && (din > r_max)) begin
      r_max <= din;
    end
  end

  assign max = r_max;

endmodule

// File: rtl/maxpool_sched.sv
// Channel-major 2x2/stride-2 max-pool scheduler. Reads four taps per
// window from the input memory, keeps the running maximum and writes one
// pooled word per window with a valid/ready handshake.
//   clk, rst           : clock, synchronous active-low reset
//   start              : single-cycle request to pool the whole tensor
//   busy, done         : job in flight / one-cycle completion pulse
//   rd_en, rd_addr     : input read strobe and address (data one cycle later)
//   rd_data            : signed input word
//   wr_en, wr_addr,
//   wr_data, wr_ready  : output write request, held until wr_ready
module maxpool_sched
  import maxpool_sched_pkg::*;
#(
  parameter  int unsigned WIDTH_IN  = 32,
  parameter  int unsigned HEIGHT_IN = 32,
  parameter  int unsigned CHANNELS  = 16,
  parameter  int unsigned DATA_W    = 25,
  localparam int unsigned WO        = WIDTH_IN / STRIDE,
  localparam int unsigned HO        = HEIGHT_IN / STRIDE,
  localparam int unsigned IN_AW     = in_aw(CHANNELS, WIDTH_IN, HEIGHT_IN),
  localparam int unsigned OUT_AW    = out_aw(CHANNELS, WIDTH_IN, HEIGHT_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [IN_AW-1:0]         rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [OUT_AW-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_ready
);

  localparam int unsigned CW  = clog2_min1(CHANNELS);
  localparam int unsigned PHW = clog2_min1(HO);
  localparam int unsigned PWW = clog2_min1(WO);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_c,     w_c_nxt;
  logic [PHW-1:0]   r_ph,    w_ph_nxt;
  logic [PWW-1:0]   r_pw,    w_pw_nxt;
  logic [1:0]       r_tap,   w_tap_nxt;
  logic             w_last_win;

  logic [IN_AW-1:0]  w_rd_addr_nxt;
  logic [OUT_AW-1:0] w_wr_addr_nxt;

  logic              r_busy, r_done, r_rd_en, r_wr_en;
  logic [IN_AW-1:0]  r_rd_addr;
  logic [OUT_AW-1:0] r_wr_addr;

  logic                     w_cmp_load, w_cmp_en;
  logic signed [DATA_W-1:0] w_max;

  // state and scan counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_ph    <= '0;
      r_pw    <= '0;
      r_tap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_ph    <= w_ph_nxt;
      r_pw    <= w_pw_nxt;
      r_tap   <= w_tap_nxt;
    end
  end

  // next state and next scan position
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_ph_nxt    = r_ph;
    w_pw_nxt    = r_pw;
    w_tap_nxt   = r_tap;
    w_last_win  = (r_c == CW'(CHANNELS - 1)) && (r_ph == PHW'(HO - 1)) &&
                  (r_pw == PWW'(WO - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RD;
          w_c_nxt     = '0;
          w_ph_nxt    = '0;
          w_pw_nxt    = '0;
          w_tap_nxt   = '0;
        end
      end
      RD: begin
        // tap counter wraps back to 0 on the last tap, ready for the next window
        w_tap_nxt = r_tap + 2'd1;
        if (r_tap == 2'(TAPS - 1)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = WR;
      end
      WR: begin
        if (wr_ready) begin
          if (w_last_win) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = RD;
            if (r_pw == PWW'(WO - 1)) begin
              w_pw_nxt = '0;
              if (r_ph == PHW'(HO - 1)) begin
                w_ph_nxt = '0;
                w_c_nxt  = r_c + CW'(1);
              end else begin
                w_ph_nxt = r_ph + PHW'(1);
              end
            end else begin
              w_pw_nxt = r_pw + PWW'(1);
            end
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // addresses for the upcoming cycle; tap bit 1 is the row offset, bit 0 the column
  always_comb begin
    w_rd_addr_nxt = IN_AW'(32'(w_c_nxt) * WIDTH_IN * HEIGHT_IN
                  + (STRIDE * 32'(w_ph_nxt) + 32'(w_tap_nxt[1])) * WIDTH_IN
                  + STRIDE * 32'(w_pw_nxt) + 32'(w_tap_nxt[0]));
    w_wr_addr_nxt = OUT_AW'(32'(w_c_nxt) * WO * HO + 32'(w_ph_nxt) * WO
                  + 32'(w_pw_nxt));
  end

  // registered outputs follow the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_busy    <= (w_state_nxt == RD) || (w_state_nxt == DRAIN) ||
                   (w_state_nxt == WR);
      r_done    <= (w_state_nxt == FIN);
      r_rd_en   <= (w_state_nxt == RD);
      r_rd_addr <= (w_state_nxt == RD) ? w_rd_addr_nxt : '0;
      r_wr_en   <= (w_state_nxt == WR);
      r_wr_addr <= (w_state_nxt == WR) ? w_wr_addr_nxt : '0;
    end
  end

  // data for tap t arrives while tap t+1 is being addressed; tap 3 lands in DRAIN
  assign w_cmp_load = (r_state == RD) && (r_tap == 2'd1);
  assign w_cmp_en   = ((r_state == RD) && (r_tap >= 2'd2)) || (r_state == DRAIN);

  maxpool_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk (clk),
    .rst (rst),
    .load(w_cmp_load),
    .en  (w_cmp_en),
    .din (rd_data),
    .max (w_max)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = w_max;

endmodule
